// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: run/pause/clear sequencer for the two-nibble up-counter.
// It holds a programmable terminal value (TC). The counter wraps after TC,
// or stops at TC when oneshot is high. C is a carry that can drive a
// cascaded counter stage.
// Build option: define CNT_SEQ_CTRL_BCD_EN for a two-digit BCD count
// (modulus 1..100, reset TC 8'h99, non-BCD terminal values rejected).
// Without it the count is plain 8-bit binary and reset TC is TC_DEF.
module cnt_seq_ctrl #(
    parameter logic [7:0] TC_DEF = 8'd199
) (
    input  logic       Clk,
    input  logic       MR,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       oneshot,
    input  logic       tc_wr,
    input  logic [7:0] tc_in,
    output logic [3:0] QH,
    output logic [3:0] QL,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       tc_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state, state_next;
    logic [7:0] count, count_next;
    logic [7:0] tc, tc_next;
    logic       tc_err_next;
    logic [7:0] count_inc;
    logic       tc_ok;
    logic       at_tc;

`ifdef CNT_SEQ_CTRL_BCD_EN
    localparam logic [7:0] TC_RESET = 8'h99;

    // BCD count and terminal-value legality: the units digit rolls 9 -> 0
    // into the tens digit; both digits of a new TC must be 0..9.
    always_comb begin
        if (count[3:0] == 4'd9)
            count_inc = {count[7:4] + 4'd1, 4'd0};
        else
            count_inc = {count[7:4], count[3:0] + 4'd1};
        tc_ok = (tc_in[7:4] <= 4'd9) && (tc_in[3:0] <= 4'd9);
    end
`else
    localparam logic [7:0] TC_RESET = TC_DEF;

    // Binary count: every terminal value is legal.
    always_comb begin
        count_inc = count + 8'd1;
        tc_ok     = 1'b1;
    end
`endif

    // Both encodings store the count in the same form as TC, so a plain
    // equality check is also a digit-wise check in the BCD build.
    assign at_tc = (count == tc);

    // State register.
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Count, terminal value and registered write-error pulse.
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            count  <= 8'd0;
            tc     <= TC_RESET;
            tc_err <= 1'b0;
        end else begin
            count  <= count_next;
            tc     <= tc_next;
            tc_err <= tc_err_next;
        end
    end

    // Next-state and datapath decisions. Command priority is clr > stop > start.
    // TC may only change in IDLE, where the count is 0. This keeps the count
    // from ever passing TC.
    always_comb begin
        state_next  = state;
        count_next  = count;
        tc_next     = tc;
        tc_err_next = 1'b0;

        if (tc_wr) begin
            if (state == IDLE && tc_ok)
                tc_next = tc_in;
            else
                tc_err_next = 1'b1;
        end

        if (clr) begin
            state_next = IDLE;
            count_next = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    count_next = 8'd0;
                    if (!stop && start)
                        state_next = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_next = PAUSE;
                    end else if (at_tc) begin
                        if (oneshot)
                            state_next = DONE;
                        else
                            count_next = 8'd0;
                    end else begin
                        count_next = count_inc;
                    end
                end
                PAUSE: begin
                    if (!stop && start)
                        state_next = RUN;
                end
                DONE: begin
                    if (!stop && start) begin
                        state_next = RUN;
                        count_next = 8'd0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = 8'd0;
                end
            endcase
        end
    end

    // Status outputs. C is high in the last cycle of each period, so a
    // cascaded stage can use it directly as its count enable.
    always_comb begin
        QH   = count[7:4];
        QL   = count[3:0];
        C    = (state == RUN) && at_tc && !stop && !clr;
        busy = (state == RUN) || (state == PAUSE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: directed self-checking bench for cnt_seq_ctrl.
// It exercises the binary build (TC_DEF = 199). When CNT_SEQ_CTRL_BCD_EN is
// defined it runs the BCD scenarios instead.
module tb_cnt_seq_ctrl;

    logic       Clk = 1'b0;
    logic       MR;
    logic       start, stop, clr, oneshot, tc_wr;
    logic [7:0] tc_in;
    logic [3:0] QH, QL;
    logic       C, busy, done, tc_err;
    logic [7:0] q;

    int compared = 0;
    int mismatched = 0;
    int c_pulses;

    cnt_seq_ctrl #(.TC_DEF(8'd199)) dut (
        .Clk(Clk), .MR(MR), .start(start), .stop(stop), .clr(clr),
        .oneshot(oneshot), .tc_wr(tc_wr), .tc_in(tc_in),
        .QH(QH), .QL(QL), .C(C), .busy(busy), .done(done), .tc_err(tc_err)
    );

    always #5 Clk = ~Clk;
    assign q = {QH, QL};

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic p, input logic c,
                                  input logic os, input logic w, input logic [7:0] din);
        start = s; stop = p; clr = c; oneshot = os; tc_wr = w; tc_in = din;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        MR = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        #12;
        check_output("reset_q", q, 8'd0);
        check_output("reset_C", C, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_tc_err", tc_err, 0);
        @(negedge Clk) MR = 1'b1;

`ifdef CNT_SEQ_CTRL_BCD_EN
        // BCD: run 120 cycles through modulo-100
        apply_stimulus(1, 0, 0, 0, 0, 8'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        c_pulses = 0;
        for (int i = 0; i < 120; i++) begin
            check_output("bcd_count", q, to_bcd(i % 100));
            check_output("bcd_C", C, (i % 100) == 99);
            if (C) c_pulses++;
            tick();
        end
        check_output("bcd_c_pulses", c_pulses, 1);

        // Illegal terminal value in IDLE is rejected
        apply_stimulus(0, 0, 1, 0, 0, 8'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 8'h3A);
        tick();
        check_output("bcd_tc_err_pulse", tc_err, 1);
        apply_stimulus(1, 0, 0, 0, 0, 8'd0);
        tick();
        check_output("bcd_tc_err_clear", tc_err, 0);
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        ticks(99);
        check_output("bcd_tc_kept_q", q, 8'h99);
        check_output("bcd_tc_kept_C", C, 1);

        // Legal terminal value 23 gives period 24
        apply_stimulus(0, 0, 1, 0, 0, 8'd0);
        tick();
        apply_stimulus(1, 0, 0, 0, 1, 8'h23);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 48; i++) begin
            check_output("bcd23_count", q, to_bcd(i % 24));
            check_output("bcd23_C", C, (i % 24) == 23);
            tick();
        end
`else
        // Free run over two modulo-200 periods
        apply_stimulus(1, 0, 0, 0, 0, 8'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        c_pulses = 0;
        for (int i = 0; i < 400; i++) begin
            check_output("run_count", q, i % 200);
            check_output("run_C", C, (i % 200) == 199);
            check_output("run_busy", busy, 1);
            if (C) c_pulses++;
            tick();
        end
        check_output("run_c_pulses", c_pulses, 2);

        // Pause at 37, rejected TC write while paused, then resume
        ticks(37);
        check_output("pre_stop_q", q, 8'd37);
        apply_stimulus(0, 1, 0, 0, 0, 8'd0);
        tick();
        check_output("pause1_q", q, 8'd37);
        check_output("pause_busy", busy, 1);
        apply_stimulus(0, 1, 0, 0, 1, 8'd10);
        tick();
        check_output("pause2_q", q, 8'd37);
        check_output("pause_tc_err", tc_err, 1);
        apply_stimulus(0, 1, 0, 0, 0, 8'd0);
        tick();
        check_output("pause3_q", q, 8'd37);
        check_output("tc_err_one_cycle", tc_err, 0);
        apply_stimulus(1, 0, 0, 0, 0, 8'd0);
        tick();
        check_output("resume_q", q, 8'd37);
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        tick();
        check_output("resume_inc_q", q, 8'd38);
        ticks(161);
        check_output("tc_unchanged_q", q, 8'd199);
        check_output("tc_unchanged_C", C, 1);

        // clr beats start at count 120
        ticks(121);
        check_output("pre_clr_q", q, 8'd120);
        apply_stimulus(1, 0, 1, 0, 0, 8'd0);
        check_output("clr_C", C, 0);
        tick();
        check_output("clr_q", q, 8'd0);
        check_output("clr_busy", busy, 0);
        check_output("clr_done", done, 0);

        // One-shot with TC = 5
        apply_stimulus(0, 0, 0, 0, 1, 8'd5);
        tick();
        check_output("idle_wr_no_err", tc_err, 0);
        apply_stimulus(1, 0, 0, 1, 0, 8'd0);
        tick();
        check_output("os_busy", busy, 1);
        apply_stimulus(0, 0, 0, 1, 0, 8'd0);
        c_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            check_output("os_count", q, i);
            check_output("os_C", C, i == 5);
            if (C) c_pulses++;
            tick();
        end
        check_output("os_done", done, 1);
        check_output("os_QL", QL, 4'd5);
        check_output("os_QH", QH, 4'd0);
        check_output("os_busy_low", busy, 0);
        check_output("os_C_low", C, 0);
        check_output("os_c_pulses", c_pulses, 1);
        tick();
        check_output("os_hold_done", done, 1);
        check_output("os_hold_QL", QL, 4'd5);
        apply_stimulus(1, 0, 0, 1, 0, 8'd0);
        tick();
        check_output("restart_q", q, 8'd0);
        check_output("restart_done", done, 0);
        check_output("restart_busy", busy, 1);
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        tick();
        check_output("restart_inc_q", q, 8'd1);

        // TC = 0 written together with start
        apply_stimulus(0, 0, 1, 0, 0, 8'd0);
        tick();
        apply_stimulus(1, 0, 0, 0, 1, 8'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        check_output("tc0_busy", busy, 1);
        check_output("tc0_C_first", C, 1);
        check_output("tc0_q_first", q, 8'd0);
        tick();
        check_output("tc0_q", q, 8'd0);
        check_output("tc0_C", C, 1);
        apply_stimulus(0, 1, 0, 0, 0, 8'd0);
        check_output("tc0_C_stop", C, 0);
        tick();
        check_output("tc0_pause_busy", busy, 1);

        // Asynchronous reset at count 50 restores TC_DEF
        apply_stimulus(0, 0, 1, 0, 0, 8'd0);
        tick();
        apply_stimulus(1, 0, 0, 0, 1, 8'd80);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        ticks(50);
        check_output("pre_mr_q", q, 8'd50);
        MR = 1'b0;
        #1;
        check_output("mr_q", q, 8'd0);
        check_output("mr_busy", busy, 0);
        check_output("mr_done", done, 0);
        check_output("mr_C", C, 0);
        @(negedge Clk) MR = 1'b1;
        apply_stimulus(1, 0, 0, 0, 0, 8'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 8'd0);
        ticks(199);
        check_output("mr_tc_def_q", q, 8'd199);
        check_output("mr_tc_def_C", C, 1);
        tick();
        check_output("mr_tc_def_wrap", q, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
